// File: rtl/chess_pkg.sv
// Shared encodings for the chess clock turn arbiter: FSM states, move limit,
// side identifiers and the digit zero test.
package chess_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN_A = 3'd1,
    ST_RUN_B = 3'd2,
    ST_INC_A = 3'd3,
    ST_INC_B = 3'd4,
    ST_PAUSE = 3'd5,
    ST_FLAG  = 3'd6
  } state_t;

  localparam logic [6:0] MOVE_MAX = 7'd99;
  localparam logic       SIDE_A   = 1'b0;
  localparam logic       SIDE_B   = 1'b1;

  // Digits are opaque BCD: a clock is out of time only when all four read zero.
  function automatic logic isZero(input logic [15:0] digits);
    return (digits == 16'd0);
  endfunction

endpackage

// File: rtl/inc_pulser.sv
// Fischer increment sequencer: after go, emits count secup pulses, each
// followed by one gap cycle, and flags done on the final gap cycle.
module inc_pulser (
  input  logic       clk,
  input  logic       clr,
  input  logic       go,
  input  logic [3:0] count,
  output logic       pulse,
  output logic       done
);

  logic       active_r;
  logic       phase_r;
  logic [3:0] cnt_r;
  logic       pulse_r;
  logic       done_s;

  // Last gap cycle of the last pulse; count is never 0 while active.
  assign done_s = active_r & phase_r & (cnt_r == (count - 4'd1));

  // Phase toggles every cycle; a pulse is counted when its gap cycle completes.
  always_ff @(posedge clk) begin
    if (clr) begin
      active_r <= 1'b0;
      phase_r  <= 1'b0;
      cnt_r    <= 4'd0;
      pulse_r  <= 1'b0;
    end else if (go) begin
      active_r <= 1'b1;
      phase_r  <= 1'b0;
      cnt_r    <= 4'd0;
      pulse_r  <= 1'b1;
    end else if (active_r) begin
      phase_r  <= ~phase_r;
      cnt_r    <= phase_r ? (cnt_r + 4'd1) : cnt_r;
      active_r <= ~done_s;
      pulse_r  <= phase_r & ~done_s;
    end else begin
      pulse_r  <= 1'b0;
    end
  end

  assign pulse = pulse_r;
  assign done  = done_s;

endmodule

// File: rtl/chess_turn_ctrl.sv
// Turn arbiter for a two-player chess clock: gates both countdowns, issues
// Fischer increments, detects flag fall and counts full moves.
module chess_turn_ctrl #(
  parameter int INC_SEC = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       pause,
  input  logic       press_a,
  input  logic       press_b,
  input  logic [3:0] a_m2,
  input  logic [3:0] a_m1,
  input  logic [3:0] a_s2,
  input  logic [3:0] a_s1,
  input  logic [3:0] b_m2,
  input  logic [3:0] b_m1,
  input  logic [3:0] b_s2,
  input  logic [3:0] b_s1,
  output logic       run_a,
  output logic       run_b,
  output logic       inc_a,
  output logic       inc_b,
  output logic       flag_a,
  output logic       flag_b,
  output logic [6:0] move_cnt,
  output logic       paused
);
  import chess_pkg::*;

  localparam logic [3:0] INC_CNT = 4'(INC_SEC);
  localparam logic       HAS_INC = (INC_SEC != 0);

  state_t     state_r, nextState_s;
  logic       savedSide_r, nextSide_s;
  logic       incGo_s, moveTake_s;
  logic       zeroA_s, zeroB_s;
  logic       pulse_s, incDone_s;
  logic       runA_r, runB_r, flagA_r, flagB_r, paused_r;
  logic [6:0] moveCnt_r;

  assign zeroA_s = isZero({a_m2, a_m1, a_s2, a_s1});
  assign zeroB_s = isZero({b_m2, b_m1, b_s2, b_s1});

  inc_pulser u_pulser (
    .clk   (clk),
    .clr   (clr),
    .go    (incGo_s),
    .count (INC_CNT),
    .pulse (pulse_s),
    .done  (incDone_s)
  );

  // State and saved-side registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= ST_IDLE;
      savedSide_r <= SIDE_A;
    end else begin
      state_r     <= nextState_s;
      savedSide_r <= nextSide_s;
    end
  end

  // Next-state decode; zero check outranks own press, own press outranks pause.
  always_comb begin
    nextState_s = state_r;
    nextSide_s  = savedSide_r;
    incGo_s     = 1'b0;
    moveTake_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) nextState_s = ST_RUN_A;
        else       nextState_s = ST_IDLE;
      end
      ST_RUN_A: begin
        if (zeroA_s) begin
          nextState_s = ST_FLAG;
        end else if (press_a) begin
          if (HAS_INC) begin
            nextState_s = ST_INC_A;
            incGo_s     = 1'b1;
          end else begin
            nextState_s = ST_RUN_B;
          end
        end else if (pause) begin
          nextState_s = ST_PAUSE;
          nextSide_s  = SIDE_A;
        end else begin
          nextState_s = ST_RUN_A;
        end
      end
      ST_RUN_B: begin
        if (zeroB_s) begin
          nextState_s = ST_FLAG;
        end else if (press_b) begin
          moveTake_s = 1'b1;
          if (HAS_INC) begin
            nextState_s = ST_INC_B;
            incGo_s     = 1'b1;
          end else begin
            nextState_s = ST_RUN_A;
          end
        end else if (pause) begin
          nextState_s = ST_PAUSE;
          nextSide_s  = SIDE_B;
        end else begin
          nextState_s = ST_RUN_B;
        end
      end
      ST_INC_A: begin
        if (incDone_s) nextState_s = ST_RUN_B;
        else           nextState_s = ST_INC_A;
      end
      ST_INC_B: begin
        if (incDone_s) nextState_s = ST_RUN_A;
        else           nextState_s = ST_INC_B;
      end
      ST_PAUSE: begin
        if (pause) nextState_s = (savedSide_r == SIDE_A) ? ST_RUN_A : ST_RUN_B;
        else       nextState_s = ST_PAUSE;
      end
      ST_FLAG: begin
        nextState_s = ST_FLAG;
      end
      default: begin
        nextState_s = ST_IDLE;
      end
    endcase
  end

  // Moore outputs registered from the next state; flags are sticky until clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      runA_r    <= 1'b0;
      runB_r    <= 1'b0;
      paused_r  <= 1'b0;
      flagA_r   <= 1'b0;
      flagB_r   <= 1'b0;
      moveCnt_r <= 7'd0;
    end else begin
      runA_r    <= (nextState_s == ST_RUN_A);
      runB_r    <= (nextState_s == ST_RUN_B);
      paused_r  <= (nextState_s == ST_PAUSE);
      flagA_r   <= flagA_r | ((state_r == ST_RUN_A) & zeroA_s);
      flagB_r   <= flagB_r | ((state_r == ST_RUN_B) & zeroB_s);
      if (moveTake_s && (moveCnt_r != MOVE_MAX)) moveCnt_r <= moveCnt_r + 7'd1;
      else                                       moveCnt_r <= moveCnt_r;
    end
  end

  assign run_a    = runA_r;
  assign run_b    = runB_r;
  assign paused   = paused_r;
  assign flag_a   = flagA_r;
  assign flag_b   = flagB_r;
  assign move_cnt = moveCnt_r;
  assign inc_a    = pulse_s & (state_r == ST_INC_A);
  assign inc_b    = pulse_s & (state_r == ST_INC_B);

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Scoreboard bench for chess_turn_ctrl: directed stimulus pushes expected
// output vectors, a negedge monitor pops and compares them.
module tb_chess_turn_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, start, pause, press_a, press_b;
  logic [15:0] aDig, bDig;

  logic run_a, run_b, inc_a, inc_b, flag_a, flag_b, paused;
  logic [6:0] move_cnt;
  logic run_a0, run_b0, inc_a0, inc_b0, flag_a0, flag_b0, paused0;
  logic [6:0] move_cnt0;

  chess_turn_ctrl #(.INC_SEC(2)) dut (
    .clk(clk), .clr(clr), .start(start), .pause(pause),
    .press_a(press_a), .press_b(press_b),
    .a_m2(aDig[15:12]), .a_m1(aDig[11:8]), .a_s2(aDig[7:4]), .a_s1(aDig[3:0]),
    .b_m2(bDig[15:12]), .b_m1(bDig[11:8]), .b_s2(bDig[7:4]), .b_s1(bDig[3:0]),
    .run_a(run_a), .run_b(run_b), .inc_a(inc_a), .inc_b(inc_b),
    .flag_a(flag_a), .flag_b(flag_b), .move_cnt(move_cnt), .paused(paused)
  );

  chess_turn_ctrl #(.INC_SEC(0)) dut0 (
    .clk(clk), .clr(clr), .start(start), .pause(pause),
    .press_a(press_a), .press_b(press_b),
    .a_m2(aDig[15:12]), .a_m1(aDig[11:8]), .a_s2(aDig[7:4]), .a_s1(aDig[3:0]),
    .b_m2(bDig[15:12]), .b_m1(bDig[11:8]), .b_s2(bDig[7:4]), .b_s1(bDig[3:0]),
    .run_a(run_a0), .run_b(run_b0), .inc_a(inc_a0), .inc_b(inc_b0),
    .flag_a(flag_a0), .flag_b(flag_b0), .move_cnt(move_cnt0), .paused(paused0)
  );

  logic [13:0] outV, outV0;
  assign outV  = {run_a,  run_b,  inc_a,  inc_b,  flag_a,  flag_b,  paused,  move_cnt};
  assign outV0 = {run_a0, run_b0, inc_a0, inc_b0, flag_a0, flag_b0, paused0, move_cnt0};

  typedef struct {
    int          cyc;
    bit          which;
    logic [13:0] exp;
    string       name;
  } exp_t;

  exp_t sbQ[$];
  exp_t mon;
  logic [13:0] act;
  int cyc = 0;
  int nCmp = 0;
  int nBad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      mon = sbQ.pop_front();
      act = mon.which ? outV0 : outV;
      nCmp++;
      if (act !== mon.exp) begin
        nBad++;
        $display("FAIL %s cyc=%0d dut%0d actual=%h required=%h",
                 mon.name, mon.cyc, mon.which, act, mon.exp);
      end
    end
  end

  function automatic logic [13:0] ov(int ra, int rb, int ia, int ib, int fa, int fb, int p, int mc);
    return {1'(ra), 1'(rb), 1'(ia), 1'(ib), 1'(fa), 1'(fb), 1'(p), 7'(mc)};
  endfunction

  task automatic expOut(string nm, logic [13:0] e, bit w = 1'b0);
    exp_t x;
    x.cyc = cyc; x.which = w; x.exp = e; x.name = nm;
    sbQ.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr = 1'b0; start = 1'b0; pause = 1'b0; press_a = 1'b0; press_b = 1'b0;
  endtask

  task automatic moveA(int mc);
    press_a = 1'b1;
    tick(); expOut("incA_p1",  ov(0,0,1,0,0,0,0,mc));
    tick(); expOut("incA_g1",  ov(0,0,0,0,0,0,0,mc));
    tick(); expOut("incA_p2",  ov(0,0,1,0,0,0,0,mc));
    tick(); expOut("incA_g2",  ov(0,0,0,0,0,0,0,mc));
    tick(); expOut("runB_aft", ov(0,1,0,0,0,0,0,mc));
  endtask

  task automatic moveB(int mc);
    press_b = 1'b1;
    tick(); expOut("incB_p1",  ov(0,0,0,1,0,0,0,mc));
    tick(); expOut("incB_g1",  ov(0,0,0,0,0,0,0,mc));
    tick(); expOut("incB_p2",  ov(0,0,0,1,0,0,0,mc));
    tick(); expOut("incB_g2",  ov(0,0,0,0,0,0,0,mc));
    tick(); expOut("runA_aft", ov(1,0,0,0,0,0,0,mc));
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; pause = 1'b0; press_a = 1'b0; press_b = 1'b0;
    aDig = 16'h0500; bDig = 16'h0430;
    tick(); expOut("reset", ov(0,0,0,0,0,0,0,0)); expOut("reset0", ov(0,0,0,0,0,0,0,0), 1'b1);

    // Idle ignores everything except start.
    press_a = 1'b1; pause = 1'b1;
    tick(); expOut("idle_ign", ov(0,0,0,0,0,0,0,0));
    repeat (7) tick();
    start = 1'b1;
    tick(); expOut("start", ov(1,0,0,0,0,0,0,0));
    nCmp++;
    if (run_a !== 1'b1 || run_b !== 1'b0) begin
      nBad++;
      $display("FAIL direct_start run_a=%b run_b=%b", run_a, run_b);
    end
    press_b = 1'b1; start = 1'b1;
    tick(); expOut("runA_ignB", ov(1,0,0,0,0,0,0,0));

    // First full move with Fischer increments, then saturation.
    moveA(0);
    moveB(1);
    for (int i = 2; i <= 105; i++) begin
      moveA((i - 1) > 99 ? 99 : i - 1);
      moveB(i > 99 ? 99 : i);
    end

    // Pause from A, ignored pulses, resume to A.
    pause = 1'b1;
    tick(); expOut("pauseA", ov(0,0,0,0,0,0,1,99));
    nCmp++;
    if (paused !== 1'b1) begin
      nBad++;
      $display("FAIL direct_pauseA paused=%b", paused);
    end
    press_a = 1'b1;
    tick(); expOut("pause_ignA", ov(0,0,0,0,0,0,1,99));
    press_b = 1'b1; start = 1'b1; aDig = 16'h0000;
    tick(); expOut("pause_ignBz", ov(0,0,0,0,0,0,1,99));
    aDig = 16'h0500; pause = 1'b1;
    tick(); expOut("resumeA", ov(1,0,0,0,0,0,0,99));

    // Own press beats pause; pause from B resumes to B.
    pause = 1'b1;
    moveA(99);
    pause = 1'b1;
    tick(); expOut("pauseB", ov(0,0,0,0,0,0,1,99));
    pause = 1'b1;
    tick(); expOut("resumeB", ov(0,1,0,0,0,0,0,99));
    moveB(99);

    // Zero beats own press: flag A, sticky under random inputs.
    aDig = 16'h0000; press_a = 1'b1;
    tick(); expOut("flagA", ov(0,0,0,0,1,0,0,99));
    nCmp++;
    if (flag_a !== 1'b1 || inc_a !== 1'b0) begin
      nBad++;
      $display("FAIL direct_flagA flag_a=%b inc_a=%b", flag_a, inc_a);
    end
    for (int i = 0; i < 1000; i++) begin
      start = 1'($urandom_range(0, 1)); pause = 1'($urandom_range(0, 1));
      press_a = 1'($urandom_range(0, 1)); press_b = 1'($urandom_range(0, 1));
      aDig = 16'($urandom); bDig = 16'($urandom);
      tick(); expOut("flagA_hold", ov(0,0,0,0,1,0,0,99));
    end
    clr = 1'b1;
    tick(); expOut("clr_flag", ov(0,0,0,0,0,0,0,0));
    nCmp++;
    if (flag_a !== 1'b0) begin
      nBad++;
      $display("FAIL direct_clr_flag flag_a=%b", flag_a);
    end
    aDig = 16'h0500; bDig = 16'h0430;

    // Flag B: zero beats press_b and pause.
    start = 1'b1;
    tick(); expOut("start2", ov(1,0,0,0,0,0,0,0));
    moveA(0);
    bDig = 16'h0000; press_b = 1'b1; pause = 1'b1;
    tick(); expOut("flagB", ov(0,0,0,0,0,1,0,0));
    pause = 1'b1;
    tick(); expOut("flagB_hold", ov(0,0,0,0,0,1,0,0));
    clr = 1'b1;
    tick(); expOut("clr_flagB", ov(0,0,0,0,0,0,0,0));
    bDig = 16'h0430;

    // clr in the middle of an increment.
    start = 1'b1;
    tick(); expOut("start3", ov(1,0,0,0,0,0,0,0));
    press_a = 1'b1;
    tick(); expOut("midinc_p1", ov(0,0,1,0,0,0,0,0));
    clr = 1'b1;
    tick(); expOut("clr_midinc", ov(0,0,0,0,0,0,0,0));
    tick(); expOut("idle_after", ov(0,0,0,0,0,0,0,0));

    // INC_SEC=0 instance: direct hand-over and simultaneous presses.
    clr = 1'b1;
    tick(); expOut("z_reset", ov(0,0,0,0,0,0,0,0), 1'b1);
    start = 1'b1;
    tick(); expOut("z_start", ov(1,0,0,0,0,0,0,0), 1'b1);
    press_a = 1'b1;
    tick(); expOut("z_pressA", ov(0,1,0,0,0,0,0,0), 1'b1);
    nCmp++;
    if (run_b0 !== 1'b1 || inc_a0 !== 1'b0) begin
      nBad++;
      $display("FAIL direct_z_pressA run_b0=%b inc_a0=%b", run_b0, inc_a0);
    end
    press_b = 1'b1;
    tick(); expOut("z_pressB", ov(1,0,0,0,0,0,0,1), 1'b1);
    press_a = 1'b1; press_b = 1'b1;
    tick(); expOut("z_both", ov(0,1,0,0,0,0,0,1), 1'b1);
    press_b = 1'b1;
    tick(); expOut("z_pressB2", ov(1,0,0,0,0,0,0,2), 1'b1);

    repeat (2) @(negedge clk);
    #1;
    while (sbQ.size() > 0) begin
      mon = sbQ.pop_front();
      nCmp++;
      nBad++;
      $display("FAIL %s never_checked cyc=%0d required=%h", mon.name, mon.cyc, mon.exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/chess_turn_ctrl.md
Name: chess_turn_ctrl

Overview:
Turn arbiter for the two-player chess clock. It consumes the debounced, edge-detected player/start/pause pulses and the BCD digits of both per-player countdown clocks. It produces the run enables that gate each clock, the Fischer-increment second-up pulses, the flag (time-out) indications and a full-move counter. It sits upstream of both player clock instances (drives their enable and secup inputs) and downstream of them (reads their digits).

Parameters:
INC_SEC, 2, Fischer increment in seconds added to the mover's clock after each move (0..15; 0 = no increment)

Ports:
clk  in  1  system clock (single clock domain)
clr  in  1  reset, synchronous, active-high
start  in  1  single-cycle pulse: begin game
pause  in  1  single-cycle pulse: toggle pause
press_a  in  1  single-cycle pulse: player A ends turn
press_b  in  1  single-cycle pulse: player B ends turn
a_m2, a_m1, a_s2, a_s1  in  4 each  BCD digits of clock A
b_m2, b_m1, b_s2, b_s1  in  4 each  BCD digits of clock B
run_a  out  1  enable for clock A countdown
run_b  out  1  enable for clock B countdown
inc_a  out  1  single-cycle secup pulse to clock A
inc_b  out  1  single-cycle secup pulse to clock B
flag_a  out  1  A ran out of time (sticky)
flag_b  out  1  B ran out of time (sticky)
move_cnt  out  7  completed full moves, binary, saturates at 99
paused  out  1  high in PAUSE

Behaviour:
- Reset: clk and a synchronous active-high clr, sampled on posedge clk; clr has priority over every other input. After clr: state IDLE, all outputs 0, move_cnt 0, increment counter 0, saved side = A.
- All outputs are Moore, decoded from registered state. An input pulse at edge t is reflected in outputs from edge t+1.
- States: IDLE, RUN_A, RUN_B, INC_A, INC_B, PAUSE, FLAG.
- IDLE: start -> RUN_A (A moves first). All other inputs are ignored.
- RUN_A: run_a=1.
  - Zero check: if all a_* digits are 0 -> FLAG with flag_a=1. The zero check has priority over press_a and pause.
  - Otherwise, press_a -> INC_A.
  - Otherwise, pause -> PAUSE and save side=A.
  - press_b and start are ignored.
- RUN_B: symmetric to RUN_A. On press_b, move_cnt increments (saturating at 99), then -> INC_B.
- INC_A (run_a=run_b=0):
  - A phase bit and a 4-bit pulse counter are cleared on entry.
  - inc_a=1 on phase 0, 0 on phase 1; each inc_a pulse counts once.
  - After INC_SEC pulses and their trailing gap cycle (2*INC_SEC cycles total) -> RUN_B.
  - If INC_SEC=0, press_a in RUN_A goes directly to RUN_B (INC_A is never entered).
  - pause, start and press_* are ignored during INC. INC_B is symmetric (-> RUN_A).
- PAUSE: run_a=run_b=0, paused=1. pause -> RUN_<saved side>. Everything else is ignored. The zero check is not evaluated.
- FLAG: run 0, the flag stays asserted and move_cnt is frozen. Only clr exits.
- Simultaneous pulses: own press beats pause; the opponent's press is always ignored; zero beats everything.
- Digits are treated as opaque BCD. The zero test is an equality on 16 bits; values are not range-checked.
- clr mid-INC: pulses stop immediately and no partial increment continues.

Decomposition:
- Shared package chess_pkg:
  - state encoding (3-bit localparams for the 7 states)
  - MOVE_MAX=99
  - side constants SIDE_A=0, SIDE_B=1
- One natural sub-module, inc_pulser:
  - inputs: clk, clr, go (start), count
  - outputs: pulse, done
  - implements the phase/counter sequence
  - instantiated once, with its pulse routed to inc_a or inc_b by the current side

Test Plan:
1. clr, then start at cycle 10 with nonzero digits -> run_a=1 from cycle 11, run_b=0, all other outputs 0.
2. INC_SEC=2, in RUN_A press_a at edge t -> run_a=0 at t+1; inc_a high at t+1 and t+3, low at t+2 and t+4; run_b=1 from t+5; move_cnt unchanged.
3. In RUN_B press_b -> move_cnt 0->1 at next edge. Repeat 105 full moves -> move_cnt holds 99.
4. In RUN_A pause -> paused=1, run_a=0. press_a/press_b/start during pause ignored. Second pause -> RUN_A, run_a=1.
5. In RUN_A drive all a_* digits to 0 in the same cycle as press_a -> FLAG, flag_a=1, no inc_a pulse. Flag persists over 1000 cycles of random inputs until clr clears all outputs.
6. INC_SEC=0, press_a -> run_b=1 at t+1 with no inc_a pulse. Also: press_a and press_b in the same cycle during RUN_A -> only the A move is taken. clr asserted mid-INC_A -> inc_a=0 and IDLE at next edge.
